// File: rtl/life_pkg.sv
// life_pkg: shared geometry, colour constants and RGB helpers for the Game of Life frame buffer.
// Revision: 1.0
`default_nettype none

package life_pkg;

    localparam int COLS   = 128;
    localparam int ROWS   = 64;
    localparam int DSIZE  = 24;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 7;
    localparam int HANG_W = 5;

    localparam logic [DSIZE-1:0] ALIVE_RGB = 24'h00FF00;
    localparam logic [DSIZE-1:0] DEAD_RGB  = 24'h000000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [7:0] rgb_red(input logic [DSIZE-1:0] w);
        rgb_t c;
        c = rgb_t'(w);
        return c.r;
    endfunction

    function automatic logic [7:0] rgb_green(input logic [DSIZE-1:0] w);
        rgb_t c;
        c = rgb_t'(w);
        return c.g;
    endfunction

    function automatic logic [7:0] rgb_blue(input logic [DSIZE-1:0] w);
        rgb_t c;
        c = rgb_t'(w);
        return c.b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/life_frame_buffer_if.sv
// life_frame_buffer_if: engine-side row write/read and swap handshake bundle.
// Revision: 1.0
`default_nettype none

interface life_frame_buffer_if;
    import life_pkg::*;

    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COLS-1:0]  wr_data;
    logic [ROW_W-1:0] rd_row;
    logic [COLS-1:0]  rd_data;
    logic             swap_req;
    logic             swap_ack;
    logic             swap_pend;

    modport master (
        output wr_en, wr_row, wr_data, rd_row, swap_req,
        input  rd_data, swap_ack, swap_pend
    );

    modport slave (
        input  wr_en, wr_row, wr_data, rd_row, swap_req,
        output rd_data, swap_ack, swap_pend
    );

endinterface

`default_nettype wire

// File: rtl/life_bitplane.sv
// life_bitplane: ROWS x COLS cell store, one row-write port, two display bit reads, one engine row read.
// Revision: 1.0
`default_nettype none

module life_bitplane
    import life_pkg::*;
(
    input  wire logic             clk_in,
    input  wire logic             rst,
    input  wire logic             we,
    input  wire logic [ROW_W-1:0] waddr,
    input  wire logic [COLS-1:0]  wdata,
    input  wire logic [ROW_W-1:0] disp_row_a,
    input  wire logic [ROW_W-1:0] disp_row_b,
    input  wire logic [COL_W-1:0] disp_col,
    output      logic             disp_bit_a,
    output      logic             disp_bit_b,
    input  wire logic [ROW_W-1:0] eng_row,
    output      logic [COLS-1:0]  eng_data
);

    logic [COLS-1:0] r_mem [ROWS];
    logic [COLS-1:0] w_row_a;
    logic [COLS-1:0] w_row_b;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_mem[r] <= '0;
            end
        end else if (we && (int'(waddr) < ROWS)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Out-of-range rows read as all-dead rather than aliasing.
    assign w_row_a    = (int'(disp_row_a) < ROWS) ? r_mem[disp_row_a] : '0;
    assign w_row_b    = (int'(disp_row_b) < ROWS) ? r_mem[disp_row_b] : '0;
    assign disp_bit_a = w_row_a[disp_col];
    assign disp_bit_b = w_row_b[disp_col];
    assign eng_data   = (int'(eng_row) < ROWS) ? r_mem[eng_row] : '0;

endmodule

`default_nettype wire

// File: rtl/life_frame_buffer.sv
// life_frame_buffer: ping-pong cell planes with frame-boundary swap handshake and colour mapping.
// Revision: 1.0
`default_nettype none

module life_frame_buffer
    import life_pkg::*;
(
    input  wire logic              clk_in,
    input  wire logic              rst,
    input  wire logic              disp_en,
    input  wire logic              read_en,
    input  wire logic [COL_W-1:0]  Ycount,
    input  wire logic [HANG_W-1:0] hangcount,
    output      logic [DSIZE-1:0]  datain1,
    output      logic [DSIZE-1:0]  datain2,
    output      logic              frame_tick,
    life_frame_buffer_if.slave     eng
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PEND = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    logic [1:0]        r_state;
    logic              r_front_sel;
    logic              r_req_armed;
    logic [HANG_W-1:0] r_hang_prev;
    logic              r_frame_tick;

    logic              w_boundary;
    logic              w_swap_now;
    logic [ROW_W-1:0]  w_row_top;
    logic [ROW_W-1:0]  w_row_bot;
    logic              w_a_top, w_a_bot, w_b_top, w_b_bot;
    logic [COLS-1:0]   w_a_eng, w_b_eng;
    logic              w_cell_top, w_cell_bot;

    assign w_boundary = disp_en
                      & (r_hang_prev == HANG_W'(ROWS/2 - 1))
                      & (hangcount == '0);
    // With the display off there is no frame to tear, so swap immediately.
    assign w_swap_now = (r_state == c_ST_PEND) & (w_boundary | ~disp_en);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_front_sel  <= 1'b0;
            r_req_armed  <= 1'b1;
            r_hang_prev  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_hang_prev  <= hangcount;
            r_frame_tick <= w_boundary;
            case (r_state)
                c_ST_IDLE: if (eng.swap_req && r_req_armed) r_state <= c_ST_PEND;
                c_ST_PEND: if (w_swap_now) begin
                    r_state     <= c_ST_ACK;
                    r_front_sel <= ~r_front_sel;
                end
                c_ST_ACK:  r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
            // One swap per request: rearm only once the request has been dropped.
            if (w_swap_now) begin
                r_req_armed <= 1'b0;
            end else if (!eng.swap_req) begin
                r_req_armed <= 1'b1;
            end
        end
    end

    assign w_row_top = ROW_W'(hangcount);
    assign w_row_bot = ROW_W'(hangcount) + ROW_W'(ROWS/2);

    life_bitplane u_plane_a (
        .clk_in     (clk_in),
        .rst        (rst),
        .we         (eng.wr_en & r_front_sel),
        .waddr      (eng.wr_row),
        .wdata      (eng.wr_data),
        .disp_row_a (w_row_top),
        .disp_row_b (w_row_bot),
        .disp_col   (Ycount),
        .disp_bit_a (w_a_top),
        .disp_bit_b (w_a_bot),
        .eng_row    (eng.rd_row),
        .eng_data   (w_a_eng)
    );

    life_bitplane u_plane_b (
        .clk_in     (clk_in),
        .rst        (rst),
        .we         (eng.wr_en & ~r_front_sel),
        .waddr      (eng.wr_row),
        .wdata      (eng.wr_data),
        .disp_row_a (w_row_top),
        .disp_row_b (w_row_bot),
        .disp_col   (Ycount),
        .disp_bit_a (w_b_top),
        .disp_bit_b (w_b_bot),
        .eng_row    (eng.rd_row),
        .eng_data   (w_b_eng)
    );

    assign w_cell_top = r_front_sel ? w_b_top : w_a_top;
    assign w_cell_bot = r_front_sel ? w_b_bot : w_a_bot;

    assign datain1 = (read_en && w_cell_top) ? ALIVE_RGB : DEAD_RGB;
    assign datain2 = (read_en && w_cell_bot) ? ALIVE_RGB : DEAD_RGB;

    assign eng.rd_data   = r_front_sel ? w_b_eng : w_a_eng;
    assign eng.swap_ack  = (r_state == c_ST_ACK);
    assign eng.swap_pend = (r_state == c_ST_PEND);
    assign frame_tick    = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_life_frame_buffer.sv
// tb_life_frame_buffer: directed stimulus with a queued-expectation scoreboard checked at negedge.
// Revision: 1.0
`default_nettype none

module tb_life_frame_buffer;
    import life_pkg::*;

    localparam int K_D1 = 0, K_D2 = 1, K_RD = 2, K_ACK = 3, K_PEND = 4, K_TICK = 5, K_ACKCNT = 6;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              disp_en;
    logic              read_en;
    logic [COL_W-1:0]  Ycount;
    logic [HANG_W-1:0] hangcount;
    logic [DSIZE-1:0]  datain1;
    logic [DSIZE-1:0]  datain2;
    logic              frame_tick;

    life_frame_buffer_if eng_if ();

    life_frame_buffer dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .disp_en    (disp_en),
        .read_en    (read_en),
        .Ycount     (Ycount),
        .hangcount  (hangcount),
        .datain1    (datain1),
        .datain2    (datain2),
        .frame_tick (frame_tick),
        .eng        (eng_if.slave)
    );

    always #5 clk_in = ~clk_in;

    int           q_kind[$];
    logic [127:0] q_exp[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           ack_seen = 0;
    int           exp_acks = 0;

    int           m_k;
    logic [127:0] m_e;
    logic [127:0] m_act;
    string        m_name;

    always @(negedge clk_in) begin
        if (eng_if.swap_ack === 1'b1) ack_seen++;
        while (q_kind.size() > 0) begin
            m_k = q_kind.pop_front();
            m_e = q_exp.pop_front();
            case (m_k)
                K_D1:    begin m_name = "datain1";   m_act = 128'(datain1); end
                K_D2:    begin m_name = "datain2";   m_act = 128'(datain2); end
                K_RD:    begin m_name = "rd_data";   m_act = eng_if.rd_data; end
                K_ACK:   begin m_name = "swap_ack";  m_act = 128'(eng_if.swap_ack); end
                K_PEND:  begin m_name = "swap_pend"; m_act = 128'(eng_if.swap_pend); end
                K_TICK:  begin m_name = "frame_tick"; m_act = 128'(frame_tick); end
                default: begin m_name = "ack_count"; m_act = 128'(ack_seen); end
            endcase
            n_vec++;
            if (m_act !== m_e) begin
                n_bad++;
                $display("FAIL %s (rd_row=%0d hang=%0d Y=%0d): got %h expected %h",
                         m_name, eng_if.rd_row, hangcount, Ycount, m_act, m_e);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic expect_v(input int k, input logic [127:0] e);
        q_kind.push_back(k);
        q_exp.push_back(e);
    endtask

    task automatic check_rd(input logic [ROW_W-1:0] row, input logic [127:0] e);
        eng_if.rd_row = row;
        expect_v(K_RD, e);
        settle();
    endtask

    task automatic write_row(input logic [ROW_W-1:0] row, input logic [127:0] d);
        eng_if.wr_en   = 1'b1;
        eng_if.wr_row  = row;
        eng_if.wr_data = d;
        step();
        eng_if.wr_en   = 1'b0;
    endtask

    task automatic do_frame();
        hangcount = 5'd31;
        step();
        hangcount = 5'd0;
        step();
    endtask

    localparam logic [127:0] ROW3  = 128'h1 << 5;
    localparam logic [127:0] ROW35 = 128'h1 << 127;
    localparam logic [127:0] ROW10 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;

    initial begin
        rst = 1'b1;
        disp_en = 1'b1; read_en = 1'b1; Ycount = '0; hangcount = '0;
        eng_if.wr_en = 1'b0; eng_if.wr_row = '0; eng_if.wr_data = '0;
        eng_if.rd_row = '0; eng_if.swap_req = 1'b0;
        step(); step();
        rst = 1'b0;
        hangcount = 5'd5;
        step();

        // Reset state
        expect_v(K_D1, 0); expect_v(K_D2, 0); expect_v(K_ACK, 0); expect_v(K_PEND, 0);
        settle();
        for (int r = 0; r < ROWS; r++) check_rd(ROW_W'(r), 0);

        // Row 3 into back plane, swapped in at frame boundary
        write_row(6'd3, ROW3);
        check_rd(6'd3, 0);
        eng_if.swap_req = 1'b1;
        step();
        expect_v(K_PEND, 1); settle();
        hangcount = 5'd31;
        step();
        expect_v(K_ACK, 0); expect_v(K_PEND, 1); expect_v(K_RD, 0); settle();
        hangcount = 5'd0;
        step();
        exp_acks++;
        expect_v(K_ACK, 1); expect_v(K_PEND, 0); expect_v(K_TICK, 1); expect_v(K_RD, ROW3);
        settle();
        eng_if.swap_req = 1'b0;
        step();
        expect_v(K_ACK, 0); expect_v(K_TICK, 0); settle();
        hangcount = 5'd3; Ycount = 7'd5;
        expect_v(K_D1, 128'h00FF00); expect_v(K_D2, 0); settle();
        read_en = 1'b0;
        expect_v(K_D1, 0); settle();
        read_en = 1'b1;

        // Row 35 bottom-half, far column
        write_row(6'd35, ROW35);
        eng_if.swap_req = 1'b1;
        step();
        do_frame();
        exp_acks++;
        expect_v(K_ACK, 1); settle();
        eng_if.swap_req = 1'b0;
        step();
        hangcount = 5'd3; Ycount = 7'd127;
        expect_v(K_D2, 128'h00FF00); expect_v(K_D1, 0); settle();
        Ycount = 7'd5;
        expect_v(K_D1, 0); settle();
        check_rd(6'd35, ROW35);
        check_rd(6'd3, 0);

        // Held request: exactly one swap over three frames, then re-raise
        eng_if.swap_req = 1'b1;
        step();
        do_frame(); do_frame(); do_frame();
        exp_acks++;
        step();
        expect_v(K_ACKCNT, 128'(exp_acks)); settle();
        check_rd(6'd3, ROW3);
        eng_if.swap_req = 1'b0;
        step();
        eng_if.swap_req = 1'b1;
        step();
        do_frame();
        exp_acks++;
        step();
        expect_v(K_ACKCNT, 128'(exp_acks)); settle();
        check_rd(6'd3, 0);
        eng_if.swap_req = 1'b0;
        step();

        // Display disabled: immediate swap, write in the swap cycle shows in the new front
        disp_en = 1'b0; hangcount = 5'd7;
        eng_if.swap_req = 1'b1;
        step();
        expect_v(K_PEND, 1); expect_v(K_ACK, 0); settle();
        eng_if.rd_row = 6'd10;
        write_row(6'd10, ROW10);
        exp_acks++;
        expect_v(K_ACK, 1); expect_v(K_PEND, 0); expect_v(K_RD, ROW10); settle();
        check_rd(6'd3, ROW3);
        eng_if.swap_req = 1'b0;
        step();
        expect_v(K_ACK, 0); settle();

        // Reset with a swap pending
        disp_en = 1'b1; hangcount = 5'd10;
        eng_if.swap_req = 1'b1;
        step();
        expect_v(K_PEND, 1); settle();
        rst = 1'b1;
        #1;
        hangcount = 5'd3; Ycount = 7'd5;
        expect_v(K_PEND, 0); expect_v(K_ACK, 0); expect_v(K_D1, 0); expect_v(K_RD, 0);
        settle();
        eng_if.swap_req = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        expect_v(K_ACKCNT, 128'(exp_acks)); expect_v(K_PEND, 0); settle();
        write_row(6'd3, ROW3);
        check_rd(6'd3, 0);
        expect_v(K_D1, 0); settle();

        settle(); settle();
        if (q_kind.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q_kind.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
